jk_exciter: RTL and testbench

JK_EXCITER -- requirements
Module: jk_exciter

---
 rtl/jk_exciter_if.sv | 30 +++
 rtl/jk_exciter.sv | 114 +++++++++++
 tb/tb_jk_exciter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_exciter_if.sv
// Request-side bundle for jk_exciter: target handshake and status.
// The requester uses master; the exciter uses slave.
interface jk_exciter_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output tgt_valid,
    output tgt,
    input  tgt_ready,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  tgt_valid,
    input  tgt,
    output tgt_ready,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/jk_exciter.sv
// Drives a bank of JK flip-flops toward a requested state,
// verifying through q feedback and re-driving on failure.
module jk_exciter #(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 3,
  parameter int USE_TOGGLE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  jk_exciter_if.slave        req,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [2*WIDTH-1:0] jk
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_e;

  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] jk_q, jk_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [2:0]         retry_q, retry_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Per-bit excitation: hold matching bits, set/reset or toggle the rest.
  function automatic logic [2*WIDTH-1:0] excite(
    input logic [WIDTH-1:0] t,
    input logic [WIDTH-1:0] q
  );
    logic [2*WIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (t[i] != q[i]) begin
        if (USE_TOGGLE != 0) e[2*i +: 2] = 2'b11;
        else                 e[2*i +: 2] = {t[i], ~t[i]};
      end
    end
    return e;
  endfunction

  // Next-state: accept in IDLE, one-cycle drive, one-cycle check.
  always_comb begin
    state_d = state_q;
    jk_d    = jk_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        jk_d = '0;
        if (req.tgt_valid) begin
          tgt_d   = req.tgt;
          jk_d    = excite(req.tgt, q_fb);
          retry_d = '0;
          err_d   = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        jk_d    = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 3'd1;
          jk_d    = excite(tgt_q, q_fb);
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        jk_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears jk without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      jk_q    <= '0;
      tgt_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      jk_q    <= jk_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign jk            = jk_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign req.busy      = (state_q != IDLE);
  assign req.tgt_ready = (state_q == IDLE);

endmodule

// File: tb/tb_jk_exciter.sv
// Directed bench for jk_exciter driving a modelled JK bank.
// Two instances: set/reset excitation and toggle excitation.
module tb_jk_exciter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] jk, jk_t;
  logic [3:0] bank_q, bank_t, q_fb;
  logic [3:0] pre_val = 4'b0000;
  logic [3:0] stuck_val = 4'b0000;
  bit         pre_en = 1'b0;
  bit         stuck_en = 1'b0;
  int         nvec = 0;
  int         nerr = 0;

  jk_exciter_if #(.WIDTH(4)) rq ();
  jk_exciter_if #(.WIDTH(4)) rt ();

  always #5 clk = ~clk;

  assign q_fb = stuck_en ? stuck_val : bank_q;

  jk_exciter #(.WIDTH(4), .MAX_RETRY(3), .USE_TOGGLE(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .q_fb  (q_fb),
    .jk    (jk)
  );

  jk_exciter #(.WIDTH(4), .MAX_RETRY(3), .USE_TOGGLE(1)) dut_t (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rt),
    .q_fb  (bank_t),
    .jk    (jk_t)
  );

  function automatic logic [3:0] jk_next(
    input logic [3:0] q,
    input logic [7:0] e
  );
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case (e[2*i +: 2])
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  // Behavioural JK flip-flop banks with a bench-side preset.
  always @(posedge clk) begin
    if (pre_en) begin
      bank_q <= pre_val;
      bank_t <= pre_val;
    end else begin
      bank_q <= jk_next(bank_q, jk);
      bank_t <= jk_next(bank_t, jk_t);
    end
  end

  task automatic set_bank(input logic [3:0] v);
    pre_en  = 1'b1;
    pre_val = v;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    nvec++; if (jk !== 8'h00) begin nerr++;
      $display("FAIL rst_jk got %h want 00", jk); end
    nvec++; if (rq.done !== 1'b0) begin nerr++;
      $display("FAIL rst_done got %b want 0", rq.done); end
    nvec++; if (rq.err !== 1'b0) begin nerr++;
      $display("FAIL rst_err got %b want 0", rq.err); end
    nvec++; if (rq.busy !== 1'b0) begin nerr++;
      $display("FAIL rst_busy got %b want 0", rq.busy); end
    nvec++; if (rq.tgt_ready !== 1'b1) begin nerr++;
      $display("FAIL rst_ready got %b want 1", rq.tgt_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_set_reset();
    set_bank(4'b0000);
    rq.tgt = 4'b1010;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    nvec++; if (jk !== 8'b10001000) begin nerr++;
      $display("FAIL sr_jk got %b want 10001000", jk); end
    nvec++; if (rq.busy !== 1'b1) begin nerr++;
      $display("FAIL sr_busy got %b want 1", rq.busy); end
    nvec++; if (rq.tgt_ready !== 1'b0) begin nerr++;
      $display("FAIL sr_ready got %b want 0", rq.tgt_ready); end
    @(negedge clk);
    nvec++; if (jk !== 8'h00) begin nerr++;
      $display("FAIL sr_jk2 got %b want 0", jk); end
    nvec++; if (bank_q !== 4'b1010) begin nerr++;
      $display("FAIL sr_bank got %b want 1010", bank_q); end
    nvec++; if (rq.done !== 1'b0) begin nerr++;
      $display("FAIL sr_early got %b want 0", rq.done); end
    @(negedge clk);
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL sr_done got %b want 1", rq.done); end
    nvec++; if (rq.err !== 1'b0) begin nerr++;
      $display("FAIL sr_err got %b want 0", rq.err); end
    nvec++; if (rq.busy !== 1'b0) begin nerr++;
      $display("FAIL sr_idle got %b want 0", rq.busy); end
    @(negedge clk);
    nvec++; if (rq.done !== 1'b0) begin nerr++;
      $display("FAIL sr_pulse got %b want 0", rq.done); end
  endtask

  task automatic test_toggle();
    set_bank(4'b1100);
    rt.tgt = 4'b0110;
    rt.tgt_valid = 1'b1;
    @(negedge clk);
    rt.tgt_valid = 1'b0;
    nvec++; if (jk_t !== 8'b11001100) begin nerr++;
      $display("FAIL tg_jk got %b want 11001100", jk_t); end
    @(negedge clk);
    nvec++; if (bank_t !== 4'b0110) begin nerr++;
      $display("FAIL tg_bank got %b want 0110", bank_t); end
    @(negedge clk);
    nvec++; if (rt.done !== 1'b1) begin nerr++;
      $display("FAIL tg_done got %b want 1", rt.done); end
    @(negedge clk);
  endtask

  task automatic test_retry_err();
    int drives = 0;
    int dones = 0;
    logic [7:0] exp_jk;
    set_bank(4'b0000);
    stuck_en = 1'b1;
    stuck_val = 4'b0000;
    rq.tgt = 4'b0001;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_jk = (k % 2 == 0) ? 8'h02 : 8'h00;
      if (jk === 8'h02) drives++;
      if (rq.done === 1'b1) dones++;
      nvec++; if (jk !== exp_jk) begin nerr++;
        $display("FAIL rt_jk c%0d got %b want %b", k, jk, exp_jk); end
      nvec++; if (rq.err !== 1'b0) begin nerr++;
        $display("FAIL rt_err_early c%0d got %b want 0", k, rq.err); end
      @(negedge clk);
    end
    nvec++; if (rq.err !== 1'b1) begin nerr++;
      $display("FAIL rt_err got %b want 1", rq.err); end
    nvec++; if (rq.done !== 1'b0) begin nerr++;
      $display("FAIL rt_done got %b want 0", rq.done); end
    nvec++; if (rq.busy !== 1'b0) begin nerr++;
      $display("FAIL rt_busy got %b want 0", rq.busy); end
    nvec++; if (drives != 4) begin nerr++;
      $display("FAIL rt_drives got %0d want 4", drives); end
    nvec++; if (dones != 0) begin nerr++;
      $display("FAIL rt_dones got %0d want 0", dones); end
    @(negedge clk);
    nvec++; if (rq.err !== 1'b1) begin nerr++;
      $display("FAIL rt_sticky got %b want 1", rq.err); end
    stuck_en = 1'b0;
    rq.tgt = 4'b0001;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    nvec++; if (rq.err !== 1'b0) begin nerr++;
      $display("FAIL rt_clr got %b want 0", rq.err); end
    nvec++; if (jk !== 8'h00) begin nerr++;
      $display("FAIL rt_jk_eq got %b want 0", jk); end
    @(negedge clk);
    @(negedge clk);
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL rt_done2 got %b want 1", rq.done); end
  endtask

  task automatic test_reset_mid_drive();
    set_bank(4'b0000);
    rq.tgt = 4'b1111;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    nvec++; if (jk !== 8'hAA) begin nerr++;
      $display("FAIL md_jk got %h want aa", jk); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (jk !== 8'h00) begin nerr++;
      $display("FAIL md_jk_rst got %h want 00", jk); end
    nvec++; if (rq.busy !== 1'b0) begin nerr++;
      $display("FAIL md_busy got %b want 0", rq.busy); end
    nvec++; if (rq.err !== 1'b0) begin nerr++;
      $display("FAIL md_err got %b want 0", rq.err); end
    rq.tgt = 4'b0011;
    rq.tgt_valid = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    nvec++; if (bank_q !== 4'b0000) begin nerr++;
      $display("FAIL md_bank got %b want 0000", bank_q); end
    nvec++; if (jk !== 8'h0A) begin nerr++;
      $display("FAIL md_jk2 got %h want 0a", jk); end
    @(negedge clk);
    @(negedge clk);
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL md_done got %b want 1", rq.done); end
    nvec++; if (bank_q !== 4'b0011) begin nerr++;
      $display("FAIL md_bank2 got %b want 0011", bank_q); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    set_bank(4'b0000);
    rq.tgt = 4'b0100;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    rq.tgt = 4'b1001;
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    rq.tgt = 4'b1111;
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL bb_done1 got %b want 1", rq.done); end
    nvec++; if (bank_q !== 4'b0100) begin nerr++;
      $display("FAIL bb_bank1 got %b want 0100", bank_q); end
    nvec++; if (rq.tgt_ready !== 1'b1) begin nerr++;
      $display("FAIL bb_ready got %b want 1", rq.tgt_ready); end
    rq.tgt = 4'b0010;
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    rq.tgt_valid = 1'b0;
    nvec++; if (rq.busy !== 1'b1) begin nerr++;
      $display("FAIL bb_busy got %b want 1", rq.busy); end
    nvec++; if (jk !== 8'b00011000) begin nerr++;
      $display("FAIL bb_jk got %b want 00011000", jk); end
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL bb_done2 got %b want 1", rq.done); end
    nvec++; if (bank_q !== 4'b0010) begin nerr++;
      $display("FAIL bb_bank2 got %b want 0010", bank_q); end
    @(negedge clk);
    if (rq.done === 1'b1) dones++;
    nvec++; if (dones != 2) begin nerr++;
      $display("FAIL bb_count got %0d want 2", dones); end
  endtask

  task automatic test_equal();
    set_bank(4'b0101);
    rq.tgt = 4'b0101;
    rq.tgt_valid = 1'b1;
    @(negedge clk);
    rq.tgt_valid = 1'b0;
    nvec++; if (jk !== 8'h00) begin nerr++;
      $display("FAIL eq_jk got %b want 0", jk); end
    nvec++; if (rq.busy !== 1'b1) begin nerr++;
      $display("FAIL eq_busy got %b want 1", rq.busy); end
    @(negedge clk);
    nvec++; if (rq.done !== 1'b0) begin nerr++;
      $display("FAIL eq_early got %b want 0", rq.done); end
    @(negedge clk);
    nvec++; if (rq.done !== 1'b1) begin nerr++;
      $display("FAIL eq_done got %b want 1", rq.done); end
    nvec++; if (bank_q !== 4'b0101) begin nerr++;
      $display("FAIL eq_bank got %b want 0101", bank_q); end
    @(negedge clk);
  endtask

  initial begin
    rq.tgt_valid = 1'b0;
    rq.tgt = 4'b0000;
    rt.tgt_valid = 1'b0;
    rt.tgt = 4'b0000;
    test_reset();
    test_set_reset();
    test_toggle();
    test_retry_err();
    test_reset_mid_drive();
    test_back_to_back();
    test_equal();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
